// File: rtl/inst_prefetch_buf.sv
// inst_prefetch_buf
//   Instruction prefetch buffer sitting between the IF stage and a multi-cycle
//   instruction memory. It fetches sequential words ahead of the PC into a
//   small FIFO and serves IF from the FIFO head. A PC that differs from the
//   head address flushes the FIFO and restarts fetching at that PC.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   inst_ren           IF requests the word at inst_addr
//   inst_addr  [31:0]  requested PC (word aligned)
//   inst_data  [31:0]  FIFO head word (meaningful when inst_valid)
//   inst_valid         head hit this cycle; 0 stalls IF
//   imem_req           memory request, held until imem_ack
//   imem_addr  [31:0]  request address, stable while imem_req
//   imem_ack           memory returns imem_rdata this cycle
//   imem_rdata [31:0]  fetched word
module inst_prefetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // BUSY: live request outstanding. DRAIN: outstanding request is stale and
  // its data will be dropped when the ack arrives.
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic [31:0]   head_addr;
  logic [31:0]   pf_addr;
  logic [31:0]   req_addr;
  logic [31:0]   pf_eff;
  logic          match;
  logic          hit;
  logic          redirect;
  logic          ack;
  logic          push;
  logic          launch;

  always_comb begin
    match     = (inst_addr == head_addr);
    hit       = inst_ren && match && (count != '0);
    redirect  = inst_ren && !match;
    ack       = imem_ack && (state != IDLE);
    push      = ack && (state == BUSY) && !redirect;
    pf_eff    = redirect ? inst_addr : pf_addr;
    count_nxt = count;
    if (redirect)
      count_nxt = '0;
    else
      count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, hit};
    // A new request may go out once no live request remains after this edge
    // and the post-edge occupancy leaves room for its data.
    launch = 1'b0;
    unique case (state)
      IDLE:    launch = (count_nxt < DEPTH_C);
      BUSY:    launch = ack && (count_nxt < DEPTH_C);
      DRAIN:   launch = ack;
      default: launch = 1'b0;
    endcase
  end

  assign inst_valid = hit;
  assign inst_data  = mem[rd_ptr];
  assign imem_req   = (state != IDLE);
  assign imem_addr  = req_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      head_addr <= RESET_PC;
      pf_addr   <= RESET_PC;
      req_addr  <= RESET_PC;
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[AW'(i)] <= '0;
    end else begin
      if (push)
        mem[wr_ptr] <= imem_rdata;

      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (hit)  rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;

      if (redirect)
        head_addr <= inst_addr;
      else if (hit)
        head_addr <= head_addr + 32'd4;

      if (launch) begin
        req_addr <= pf_eff;
        pf_addr  <= pf_eff + 32'd4;
      end else if (redirect) begin
        pf_addr  <= inst_addr;
      end

      unique case (state)
        IDLE:  if (launch) state <= BUSY;
        BUSY: begin
          if (ack)
            state <= launch ? BUSY : IDLE;
          else if (redirect)
            state <= DRAIN;
        end
        DRAIN: if (ack) state <= BUSY;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Testbench for inst_prefetch_buf: directed scenarios plus randomized fetch
// streams. The memory model returns data equal to the address, so the word
// expected for any PC is the PC itself; expected PCs are queued when IF issues
// them and a monitor pops/compares whenever the DUT reports a hit.
module tb_inst_prefetch_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  always #5 clk = ~clk;

  inst_prefetch_buf #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_ren   (inst_ren),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .inst_valid (inst_valid),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ack_q[$];

  // Memory model: acks once a request has waited `lat` cycles.
  int unsigned lat = 0;
  int unsigned wcnt;
  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = imem_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
  end

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: handshake stability, ack log, first-request recorder, scoreboard.
  int          first_req_cyc;
  logic [31:0] first_req_addr;
  logic        prev_req, prev_ack;
  logic [31:0] prev_addr;
  always @(negedge clk) begin
    if (!rst_n) begin
      first_req_cyc = -1;
      prev_req      = 1'b0;
      prev_ack      = 1'b0;
      prev_addr     = '0;
    end else begin
      if (imem_req && first_req_cyc < 0) begin
        first_req_cyc  = cyc;
        first_req_addr = imem_addr;
      end
      if (imem_req && imem_ack) ack_q.push_back(imem_addr);
      if (prev_req && !prev_ack) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_held", imem_addr, prev_addr);
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
      if (inst_ren && inst_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got pc %h data %h, no fetch pending", inst_addr, inst_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("pc_order", inst_addr, e);
          check("inst_data", inst_data, mem_word(e));
        end
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // IF model: hold the PC until the DUT delivers it; report stall cycles.
  task automatic fetch(input logic [31:0] pc, output int stalls);
    bit got;
    bit done;
    inst_ren = 1'b1;
    inst_addr = pc;
    exp_q.push_back(pc);
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      got = inst_valid;
      @(posedge clk);
      #1;
      if (got) done = 1'b1;
      else     stalls++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: pc %h not delivered within 200 cycles", pc);
      void'(exp_q.pop_back());
    end
    inst_ren = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] a);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == a) seen = 1'b1;
    end
    check("wait_req", 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inst_ren = 1'b0;
    inst_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    ack_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_ack(input int idx, input logic [31:0] a);
    if (ack_q.size() > idx) check("ack_addr", ack_q[idx], a);
    else                    check("ack_count", 32'(ack_q.size()), 32'(idx + 1));
  endtask

  initial begin
    int st;
    logic [31:0] pc;
    int r;

    rst_n = 1'b1;
    inst_ren = 1'b0;
    inst_addr = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset and fill: first valid in cycle 2, then one per cycle.
    fetch(32'h0, st);
    check("first_stalls", 32'(st), 32'd2);
    check("first_req_cyc", 32'(first_req_cyc), 32'd1);
    check("first_req_addr", first_req_addr, 32'h0);
    for (int i = 1; i < 16; i++) begin
      fetch(32'(i * 4), st);
      check("stream_stalls", 32'(st), 32'd0);
    end

    // Full FIFO with IF idle, then one pop relaunches at 0x10.
    do_reset();
    ticks(10);
    check("full_ack_count", 32'(ack_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_ack(i, 32'(i * 4));
    check("full_req_low", 32'(imem_req), 32'd0);
    fetch(32'h0, st);
    check("full_hit_stalls", 32'(st), 32'd0);
    check("relaunch_req", 32'(imem_req), 32'd1);
    check("relaunch_addr", imem_addr, 32'h10);

    // Redirect while idle with a full FIFO.
    do_reset();
    ticks(10);
    ack_q.delete();
    fetch(32'h100, st);
    check("idle_redir_stalls", 32'(st), 32'd2);
    check_ack(0, 32'h100);
    fetch(32'h104, st);
    check("post_redir_stalls", 32'(st), 32'd0);

    // Redirect while the request at 0x8 is outstanding (3-cycle memory).
    lat = 3;
    do_reset();
    wait_req(32'h8);
    ticks(1);
    ack_q.delete();
    fetch(32'h40, st);
    check("drain_stalls", 32'(st), 32'd7);
    check_ack(0, 32'h8);
    check_ack(1, 32'h40);

    // Redirect coincident with the ack for 0x4.
    lat = 2;
    do_reset();
    wait_req(32'h4);
    ticks(2);
    check("coinc_ack", 32'(imem_ack), 32'd1);
    check("coinc_addr", imem_addr, 32'h4);
    ack_q.delete();
    fetch(32'h80, st);
    check("coinc_stalls", 32'(st), 32'd4);
    check_ack(0, 32'h4);
    check_ack(1, 32'h80);

    // Asynchronous reset while a request is waiting for its ack.
    lat = 5;
    do_reset();
    ticks(8);
    inst_ren = 1'b1;
    inst_addr = 32'h0;
    #1;
    check("pre_rst_valid", 32'(inst_valid), 32'd1);
    check("pre_rst_req", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(imem_req), 32'd0);
    check("async_rst_valid", 32'(inst_valid), 32'd0);
    check("async_rst_data", inst_data, 32'h0);
    inst_ren = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ticks(3);
    check("rerst_first_cyc", 32'(first_req_cyc), 32'd1);
    check("rerst_first_addr", first_req_addr, 32'h0);

    // Randomized fetch stream: sequential runs, jumps, idle gaps, and
    // one-cycle wrong-path PCs that redirect again before being served.
    lat = 0;
    do_reset();
    pc = 32'h0;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (($urandom_range(0, 7)) == 0) lat = $urandom_range(0, 3);
      if (r < 10) begin
        ticks($urandom_range(1, 3));
      end else if (r < 20) begin
        inst_ren = 1'b1;
        inst_addr = 32'h10000 | (32'($urandom_range(0, 255)) << 2);
        ticks(1);
        inst_ren = 1'b0;
        pc = 32'($urandom_range(0, 255)) << 2;
      end else if (r < 35) begin
        pc = 32'($urandom_range(0, 255)) << 2;
      end
      fetch(pc, st);
      pc = pc + 32'd4;
    end
    ticks(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/inst_prefetch_buf.md
# inst_prefetch_buf

Instruction prefetch buffer between the pipeline core's IF stage (`inst_ren`/`inst_addr`/`inst_data`) and a multi-cycle instruction memory with a req/ack handshake. It fetches sequential words ahead of the PC into a small FIFO. It serves the IF stage from the FIFO head and tells the controller to stall IF with `inst_valid=0`. It flushes and refetches whenever the requested PC differs from the head address (branch or jump redirect).

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, at least 2.
- `RESET_PC`, 32'h0: first fetch address after reset.
- `clk`  in  1  main clock; all state on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inst_ren`  in  1  IF stage requests the instruction at `inst_addr`.
- `inst_addr`  in  32  PC requested by IF; word aligned.
- `inst_data`  out  32  instruction at FIFO head; meaningful only when `inst_valid`=1.
- `inst_valid`  out  1  head hit this cycle; 0 means IF must stall.
- `imem_req`  out  1  memory request, held until ack.
- `imem_addr`  out  32  request address; stable while `imem_req`=1.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; sampled only while `imem_req`=1.
- `imem_rdata`  in  32  fetched word.

## Operation
- State: FIFO of `DEPTH` words, `count` (0..DEPTH), `head_addr`, `pf_addr`, `req_addr`, FSM {IDLE, BUSY, DRAIN}.
- `head_addr` is the address of the FIFO head, or of the next non-stale fill when the FIFO is empty.
- `match` = (`inst_addr` == `head_addr`).
- Hit: `inst_ren` & `match` & `count`>0.
  - `inst_valid`=1 (combinational) and `inst_data`=head word.
  - At the edge: pop, and `head_addr` += 4.
- Wait: `inst_ren` & `match` & `count`==0. `inst_valid`=0; no state change beyond normal fill.
- Redirect: `inst_ren` & !`match`. `inst_valid`=0. At the edge:
  - `count`=0, `head_addr`=`inst_addr`, `pf_addr`=`inst_addr`.
  - Any outstanding request becomes stale.
- `inst_ren`=0: no pop and no redirect; prefetch continues.
- Launch condition: (`count` after this edge's push/pop) < `DEPTH`, with no non-stale request remaining outstanding.
  - On launch: `req_addr` takes the effective `pf_addr` (the redirect target if a redirect occurs this cycle), and `pf_addr` becomes that address + 4.
- `imem_req` = (state != IDLE). `imem_addr` = `req_addr`.
- FSM transitions:
  - IDLE: if the launch condition holds, launch and go to BUSY.
  - BUSY, ack, no redirect: push `imem_rdata`. If the launch condition still holds, launch back-to-back and stay in BUSY; else go to IDLE.
  - BUSY, ack, with redirect: discard `imem_rdata`, launch at `inst_addr`, stay in BUSY.
  - BUSY, no ack, with redirect: go to DRAIN. `imem_req` and `imem_addr` are held.
  - DRAIN, ack: discard the data; launch at `pf_addr` and go to BUSY.
  - DRAIN, redirect again: update `head_addr` and `pf_addr` only.
- Pushed data is never stale: a fill is only written when it belongs to the current `head_addr` sequence.
- Push and pop in the same cycle: `count` is unchanged. A pop at `count`==DEPTH frees a slot for a launch at that same edge.
- Hit and redirect are mutually exclusive by the definition of `match`.

## Timing
- Reset, asynchronous on `rst_n`=0:
  - state=IDLE, `count`=0, FIFO storage=0.
  - `head_addr`=`pf_addr`=`req_addr`=`RESET_PC`.
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst_data`=0.
- Reset asserted mid-request drops `imem_req` immediately. The memory is required to abandon that request.
- First request is at the first edge after release: `imem_req`=1 in cycle 1.
- Fill latency: ack at edge N, data at the head after edge N, `inst_valid` possible in cycle N+1.
- With a zero-wait memory (ack in the same cycle as req):
  - Steady state delivers 1 instruction per cycle.
  - Redirect penalty is 2 stall cycles: launch edge, then fill edge.
- Handshake: `imem_addr` must not change while `imem_req`=1 and no ack has been seen. There is never more than one outstanding request.
- `inst_valid` and `inst_data` are combinational from registers and `inst_addr`. There is no path from `imem_*` inputs to `inst_*` outputs.

## Test plan
- **Reset and fill:** `RESET_PC`=0, zero-wait memory returning data = addr, `inst_ren`=1 with PC stepping 0,4,8…
  - Cycle 1: `imem_req`=1, `imem_addr`=0.
  - `inst_valid` first 1 in cycle 2 with `inst_data`=0.
  - Thereafter 1 instruction per cycle with data = PC.
- **Full FIFO:** `inst_ren`=0 with a zero-wait memory.
  - Exactly 4 acks are accepted (addresses 0..C), then `imem_req`=0 and `count`=4.
  - One hit pop relaunches at 0x10 at the same edge.
- **Redirect while idle:** after the FIFO holds 0..C, `inst_addr`=0x100.
  - `inst_valid`=0; `count` becomes 0.
  - Next request `imem_addr`=0x100; `inst_data`=0x100 valid 2 cycles after the redirect.
- **Redirect while a request is outstanding:** memory has 3-cycle latency; request at 0x8 pending; redirect to 0x40.
  - `imem_addr` stays 0x8 until ack; that data is not pushed (DRAIN).
  - Next request is 0x40, and the first valid instruction is 0x40's word.
- **Redirect coincident with ack:** ack for 0x4 arrives in the same cycle as a redirect to 0x80.
  - 0x4's data is discarded and `imem_addr`=0x80 in the next cycle.
  - No stale `inst_valid` occurs.
- **Async reset mid-request:** `rst_n`=0 while waiting for an ack.
  - `imem_req`=0 and `inst_valid`=0 without a clock edge.
  - After release, the first request is at `RESET_PC`.
